// File: rtl/rand_num_reader_if.sv
// Bundle of the reader's seed, ROM and spawn-handshake signals.
// The master side is the reader; the slave side is ROM, game logic and cake spawner.
interface rand_num_reader_if;
  logic       seed_load;
  logic [7:0] seed;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic       rand_valid;
  logic       rand_ready;
  logic [7:0] rand_value;
  logic       wrapped;

  modport master (
    input  seed_load, seed, rom_data, rand_ready,
    output rom_addr, rand_valid, rand_value, wrapped
  );

  modport slave (
    output seed_load, seed, rom_data, rand_ready,
    input  rom_addr, rand_valid, rand_value, wrapped
  );
endinterface

// File: rtl/rand_num_reader.sv
// Walks the one-cycle-latency random-number ROM and clamps each word into the
// playfield X range, offering it to the cake spawner over valid/ready.
module rand_num_reader #(
  parameter int TABLE_LEN = 145,
  parameter int X_MIN     = 16,
  parameter int X_MAX     = 140
) (
  input logic               clk,
  input logic               rst,
  rand_num_reader_if.master bus
);
  localparam logic [7:0] LAST_IDX   = 8'(TABLE_LEN - 1);
  localparam logic [8:0] TABLE_LEN9 = 9'(TABLE_LEN);
  localparam logic [7:0] X_MIN8     = 8'(X_MIN);
  localparam logic [7:0] X_MAX8     = 8'(X_MAX);

  typedef enum logic [1:0] {ISSUE, WAIT, HOLD} state_e;

  state_e     state_q, state_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] value_q, value_d;
  logic       valid_q, valid_d;
  logic       wrapped_q, wrapped_d;

  function automatic logic [7:0] clamp(input logic [7:0] d);
    if (d < X_MIN8) return X_MIN8;
    if (d > X_MAX8) return X_MAX8;
    return d;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ISSUE;
      ptr_q     <= 8'd0;
      value_q   <= 8'd0;
      valid_q   <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      wrapped_q <= wrapped_d;
    end
  end

  // Seed load overrides every state and discards any fetch still in flight.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    value_d   = value_q;
    valid_d   = valid_q;
    wrapped_d = 1'b0;
    if (bus.seed_load) begin
      ptr_d   = ({1'b0, bus.seed} < TABLE_LEN9) ? bus.seed : 8'd0;
      valid_d = 1'b0;
      state_d = ISSUE;
    end else begin
      case (state_q)
        ISSUE: state_d = WAIT;
        WAIT: begin
          value_d   = clamp(bus.rom_data);
          valid_d   = 1'b1;
          ptr_d     = (ptr_q == LAST_IDX) ? 8'd0 : ptr_q + 8'd1;
          wrapped_d = (ptr_q == LAST_IDX);
          state_d   = HOLD;
        end
        HOLD: begin
          if (bus.rand_ready) begin
            valid_d = 1'b0;
            state_d = ISSUE;
          end
        end
        default: state_d = ISSUE;
      endcase
    end
  end

  // The pointer register doubles as the registered ROM address.
  assign bus.rom_addr   = ptr_q;
  assign bus.rand_valid = valid_q;
  assign bus.rand_value = value_q;
  assign bus.wrapped    = wrapped_q;
endmodule

// File: tb/tb_rand_num_reader.sv
// Self-checking bench for rand_num_reader: directed scenarios plus a randomized
// run scored against a table-index model of the reader.
module tb_rand_num_reader;
  localparam int TABLE_LEN = 145;
  localparam int X_MIN     = 16;
  localparam int X_MAX     = 140;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rand_num_reader_if bus();

  rand_num_reader #(
    .TABLE_LEN(TABLE_LEN),
    .X_MIN    (X_MIN),
    .X_MAX    (X_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] rom [256];

  // Model: index of the value currently offered (or being fetched) and
  // cycles elapsed since the last restart (reset, seed load or accept).
  int expIdx   = 0;
  int sinceCnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  function automatic int clampRef(input int d);
    if (d < X_MIN) return X_MIN;
    if (d > X_MAX) return X_MAX;
    return d;
  endfunction

  function automatic logic expValid();
    return sinceCnt >= 2;
  endfunction

  function automatic logic [7:0] expValue();
    return 8'(clampRef(int'(rom[expIdx])));
  endfunction

  function automatic logic [7:0] expAddr();
    return 8'((sinceCnt >= 2) ? (expIdx + 1) % TABLE_LEN : expIdx);
  endfunction

  function automatic logic expWrapped();
    return (sinceCnt == 2) && (expIdx == TABLE_LEN - 1);
  endfunction

  // Drive one cycle of inputs, advance the clock and update the model.
  task automatic cycle(input logic sl, input logic [7:0] sd, input logic rdy);
    logic wasValid;
    wasValid      = expValid();
    bus.seed_load = sl;
    bus.seed      = sd;
    bus.rand_ready = rdy;
    @(posedge clk);
    #1;
    if (sl) begin
      expIdx   = (int'(sd) < TABLE_LEN) ? int'(sd) : 0;
      sinceCnt = 0;
    end else if (wasValid && rdy) begin
      expIdx   = (expIdx + 1) % TABLE_LEN;
      sinceCnt = 0;
    end else if (sinceCnt < 3) begin
      sinceCnt++;
    end
    bus.seed_load = 1'b0;
  endtask

  task automatic test_reset();
    bus.seed_load  = 1'b0;
    bus.seed       = 8'd0;
    bus.rand_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.rand_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valid got %0b exp 0", bus.rand_valid);
    end
    checks++;
    if (bus.rand_value !== 8'd0) begin
      errors++; $display("[TB] FAIL reset_value got %0d exp 0", bus.rand_value);
    end
    checks++;
    if (bus.rom_addr !== 8'd0) begin
      errors++; $display("[TB] FAIL reset_addr got %0d exp 0", bus.rom_addr);
    end
    checks++;
    if (bus.wrapped !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_wrapped got %0b exp 0", bus.wrapped);
    end
    rst      = 1'b0;
    expIdx   = 0;
    sinceCnt = 0;
  endtask

  task automatic test_first_values();
    logic [7:0] expList [3];
    int waitCyc;
    int needCyc;
    expList = '{8'd73, 8'd95, 8'd71};
    for (int k = 0; k < 3; k++) begin
      needCyc = (k == 0) ? 2 : 3;
      waitCyc = 0;
      do begin
        cycle(1'b0, 8'd0, 1'b1);
        waitCyc++;
      end while (bus.rand_valid !== 1'b1 && waitCyc < 8);
      checks++;
      if (waitCyc != needCyc) begin
        errors++; $display("[TB] FAIL first_latency[%0d] got %0d cycles exp %0d", k, waitCyc, needCyc);
      end
      checks++;
      if (bus.rand_value !== expList[k]) begin
        errors++; $display("[TB] FAIL first_value[%0d] got %0d exp %0d", k, bus.rand_value, expList[k]);
      end
    end
  endtask

  task automatic test_clamp();
    logic [7:0] seeds [3];
    logic [7:0] exps  [3];
    seeds = '{8'd96, 8'd37, 8'd4};
    exps  = '{8'd16, 8'd140, 8'd35};
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, seeds[k], 1'b0);
      cycle(1'b0, 8'd0, 1'b0);
      cycle(1'b0, 8'd0, 1'b0);
      checks++;
      if (bus.rand_valid !== 1'b1 || bus.rand_value !== exps[k]) begin
        errors++;
        $display("[TB] FAIL clamp[seed=%0d] got valid=%0b value=%0d exp valid=1 value=%0d",
                 seeds[k], bus.rand_valid, bus.rand_value, exps[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 8'd0, 1'b0);
      checks++;
      if (bus.rand_valid !== 1'b1 || bus.rand_value !== 8'd35 || bus.rom_addr !== 8'd5) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d] got valid=%0b value=%0d addr=%0d exp valid=1 value=35 addr=5",
                 i, bus.rand_valid, bus.rand_value, bus.rom_addr);
      end
    end
    cycle(1'b0, 8'd0, 1'b1);
    checks++;
    if (bus.rand_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_accept_drop got %0b exp 0", bus.rand_valid);
    end
    cycle(1'b0, 8'd0, 1'b0);
    checks++;
    if (bus.rand_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_gap got %0b exp 0", bus.rand_valid);
    end
    cycle(1'b0, 8'd0, 1'b0);
    checks++;
    if (bus.rand_valid !== 1'b1 || bus.rand_value !== expValue() || bus.rom_addr !== 8'd6) begin
      errors++;
      $display("[TB] FAIL bp_next got valid=%0b value=%0d addr=%0d exp valid=1 value=%0d addr=6",
               bus.rand_valid, bus.rand_value, bus.rom_addr, expValue());
    end
  endtask

  task automatic test_wrap();
    cycle(1'b1, 8'd144, 1'b1);
    cycle(1'b0, 8'd0, 1'b1);
    cycle(1'b0, 8'd0, 1'b1);
    checks++;
    if (bus.rand_valid !== 1'b1 || bus.rand_value !== 8'd91) begin
      errors++; $display("[TB] FAIL wrap_value got valid=%0b value=%0d exp valid=1 value=91",
                         bus.rand_valid, bus.rand_value);
    end
    checks++;
    if (bus.wrapped !== 1'b1 || bus.rom_addr !== 8'd0) begin
      errors++; $display("[TB] FAIL wrap_pulse got wrapped=%0b addr=%0d exp wrapped=1 addr=0",
                         bus.wrapped, bus.rom_addr);
    end
    cycle(1'b0, 8'd0, 1'b1);
    checks++;
    if (bus.wrapped !== 1'b0) begin
      errors++; $display("[TB] FAIL wrap_one_cycle got %0b exp 0", bus.wrapped);
    end
    cycle(1'b0, 8'd0, 1'b0);
    cycle(1'b0, 8'd0, 1'b0);
    checks++;
    if (bus.rand_valid !== 1'b1 || bus.rand_value !== 8'd73 || bus.wrapped !== 1'b0) begin
      errors++; $display("[TB] FAIL wrap_next got valid=%0b value=%0d wrapped=%0b exp 1/73/0",
                         bus.rand_valid, bus.rand_value, bus.wrapped);
    end
  endtask

  task automatic test_seed_oob_collision();
    cycle(1'b1, 8'd200, 1'b0);
    checks++;
    if (bus.rom_addr !== 8'd0 || bus.rand_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL oob_addr got addr=%0d valid=%0b exp addr=0 valid=0",
                         bus.rom_addr, bus.rand_valid);
    end
    cycle(1'b0, 8'd0, 1'b0);
    cycle(1'b0, 8'd0, 1'b0);
    checks++;
    if (bus.rand_valid !== 1'b1 || bus.rand_value !== 8'd73) begin
      errors++; $display("[TB] FAIL oob_value got valid=%0b value=%0d exp 1/73",
                         bus.rand_valid, bus.rand_value);
    end
    cycle(1'b1, 8'd10, 1'b1);
    checks++;
    if (bus.rom_addr !== 8'd10 || bus.rand_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL collide_seed got addr=%0d valid=%0b exp addr=10 valid=0",
                         bus.rom_addr, bus.rand_valid);
    end
    cycle(1'b0, 8'd0, 1'b0);
    cycle(1'b0, 8'd0, 1'b0);
    checks++;
    if (bus.rand_valid !== 1'b1 || bus.rand_value !== expValue() || bus.rom_addr !== 8'd11) begin
      errors++; $display("[TB] FAIL collide_value got valid=%0b value=%0d addr=%0d exp 1/%0d/11",
                         bus.rand_valid, bus.rand_value, bus.rom_addr, expValue());
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b0, 8'd0, 1'b1);
    cycle(1'b0, 8'd0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.rand_valid !== 1'b0 || bus.rand_value !== 8'd0 ||
        bus.rom_addr !== 8'd0 || bus.wrapped !== 1'b0) begin
      errors++; $display("[TB] FAIL async_clear got valid=%0b value=%0d addr=%0d wrapped=%0b exp all 0",
                         bus.rand_valid, bus.rand_value, bus.rom_addr, bus.wrapped);
    end
    @(posedge clk);
    #1;
    rst      = 1'b0;
    expIdx   = 0;
    sinceCnt = 0;
    cycle(1'b0, 8'd0, 1'b1);
    cycle(1'b0, 8'd0, 1'b1);
    checks++;
    if (bus.rand_valid !== 1'b1 || bus.rand_value !== 8'd73) begin
      errors++; $display("[TB] FAIL async_restart got valid=%0b value=%0d exp 1/73",
                         bus.rand_valid, bus.rand_value);
    end
  endtask

  task automatic test_random();
    logic       sl;
    logic [7:0] sd;
    logic       rdy;
    for (int i = 0; i < 600; i++) begin
      sl  = ($urandom % 16) == 0;
      sd  = 8'($urandom % 256);
      rdy = 1'($urandom % 2);
      cycle(sl, sd, rdy);
      checks++;
      if (bus.rand_valid !== expValid()) begin
        errors++; $display("[TB] FAIL rnd_valid[%0d] got %0b exp %0b", i, bus.rand_valid, expValid());
      end
      if (expValid()) begin
        checks++;
        if (bus.rand_value !== expValue()) begin
          errors++; $display("[TB] FAIL rnd_value[%0d] got %0d exp %0d", i, bus.rand_value, expValue());
        end
      end
      checks++;
      if (bus.rom_addr !== expAddr() || int'(bus.rom_addr) >= TABLE_LEN) begin
        errors++; $display("[TB] FAIL rnd_addr[%0d] got %0d exp %0d", i, bus.rom_addr, expAddr());
      end
      checks++;
      if (bus.wrapped !== expWrapped()) begin
        errors++; $display("[TB] FAIL rnd_wrapped[%0d] got %0b exp %0b", i, bus.wrapped, expWrapped());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom % 256);
    rom[0]   = 8'd73;
    rom[1]   = 8'd95;
    rom[2]   = 8'd71;
    rom[4]   = 8'd35;
    rom[37]  = 8'd145;
    rom[96]  = 8'd10;
    rom[144] = 8'd91;

    test_reset();
    test_first_values();
    test_clamp();
    test_backpressure();
    test_wrap();
    test_seed_oob_collision();
    test_async_reset();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rand_num_reader.md
Name: rand_num_reader

Overview:
- Sequential reader for the registered random-number ROM `rand_num_rom`, which has one cycle of read latency.
- Walks a wrapping address pointer through the table and captures each ROM word.
- Clamps each word into the playfield X range.
- Offers the result to the cake spawner over a valid/ready handshake.
- A seed-load input lets game logic restart the sequence at any table index.

Parameters:
- TABLE_LEN, 145: number of valid ROM entries; addresses 0..TABLE_LEN-1.
- X_MIN, 16: lowest legal spawn coordinate.
- X_MAX, 140: highest legal spawn coordinate; X_MIN <= X_MAX.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- seed_load  in  1  one-cycle strobe; load pointer from seed.
- seed  in  8  table index to restart from.
- rom_addr  out  8  address to rand_num_rom; registered.
- rom_data  in  8  data from rand_num_rom; valid one cycle after the address is sampled.
- rand_valid  out  1  rand_value holds a fresh clamped value.
- rand_ready  in  1  consumer accepts rand_value this cycle.
- rand_value  out  8  clamped spawn coordinate.
- wrapped  out  1  one-cycle pulse when the pointer wraps TABLE_LEN-1 -> 0.

Behaviour:
- Interface decision: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values:
  - state = ISSUE
  - ptr = 0, rom_addr = 0
  - rand_valid = 0, rand_value = 0
  - wrapped = 0
- rom_addr is a register that always follows ptr. ptr changes only at the ISSUE/WAIT -> HOLD capture edge or on seed load.
- FSM state ISSUE:
  - rom_addr is stable; the ROM samples it at the end of this cycle.
  - Next state: WAIT.
- FSM state WAIT:
  - rom_data is valid during this cycle.
  - At the end of the cycle:
    - rand_value <= clamp(rom_data)
    - rand_valid <= 1
    - ptr <= (ptr == TABLE_LEN-1) ? 0 : ptr+1
    - wrapped <= 1 iff the pointer wrapped
  - Next state: HOLD.
- FSM state HOLD:
  - rand_valid = 1; rand_value is held stable.
  - If rand_ready = 1: rand_valid <= 0 and next state is ISSUE.
  - Otherwise remain in HOLD indefinitely, with no change to rand_value or ptr.
- Latency:
  - First valid result appears 2 cycles after reset release.
  - After an accept, the next result is valid 2 cycles later.
  - Peak throughput is one value per 3 cycles.
- clamp(d) is unsigned 8-bit:
  - d < X_MIN -> X_MIN
  - d > X_MAX -> X_MAX
  - otherwise d
- wrapped is high only in the single cycle after the wrapping capture edge.
- Seed load has priority over the FSM in every state:
  - ptr <= (seed < TABLE_LEN) ? seed : 0
  - rand_valid <= 0, wrapped <= 0, state <= ISSUE
  - rand_value keeps its old contents but is not valid.
  - An in-flight fetch is discarded.
  - If seed_load and rand_ready are both high in HOLD, the seed load wins. The value is treated as not accepted; the consumer must sample only when rand_valid = 1.
- rand_ready is ignored outside HOLD.
- rst asserted mid-operation clears all state immediately; the first fetch restarts at index 0 after release.
- Address values >= TABLE_LEN are never driven on rom_addr.

Test Plan:
- Reset, rand_ready held high, behavioral ROM model: rand_valid rises 2 cycles after reset release with rand_value = 73 (ROM[0] = 73). Subsequent values follow ROM[1] = 95, ROM[2] = 71 at 3-cycle spacing.
- Clamp: seed_load with seed = 96 (ROM[96] = 10) -> rand_value = 16. Then seed = 37 (ROM[37] = 145) -> rand_value = 140. Then seed = 4 (ROM[4] = 35) -> rand_value = 35.
- Backpressure: rand_ready low for 20 cycles in HOLD -> rand_value, rand_valid and rom_addr unchanged. Raising rand_ready for one cycle -> rand_valid drops, and the next value appears 2 cycles later.
- Wrap: seed = 144, continuous accept -> value clamp(ROM[144] = 91) = 91. wrapped pulses for exactly one cycle at that capture; the next value is 73 from address 0.
- Seed out of range and collision: seed = 200 -> fetch from address 0. seed_load coincident with rand_ready in HOLD -> the seed path is taken and no double advance occurs.
- Async reset asserted mid-WAIT, between clock edges -> all outputs go to 0 immediately. After release, the sequence restarts at address 0 and yields 73.
